// File: rtl/alu_share_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl_pkg
// Shared definitions for the ALU time-sharing controller:
//   - ALU_* op code encodings understood by the shared combinational ALU
//   - controller FSM state encoding
//   - helpers classifying op codes (multicycle window, divide-type ops)
// -----------------------------------------------------------------------------
package alu_share_ctrl_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_MUL  = 4'd10;
  localparam logic [3:0] ALU_DIV  = 4'd11;
  localparam logic [3:0] ALU_MOD  = 4'd12;

  // Width of the EXEC window down-counter; holds MULDIV_CYCLES-1 (0..14).
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Ops whose ALU path is a multicycle path and need the long window.
  function automatic logic is_multicycle(input logic [3:0] op);
    return op inside {ALU_MUL, ALU_DIV, ALU_MOD};
  endfunction

  // Ops for which a zero divisor is reported on rsp_dz.
  function automatic logic is_divide(input logic [3:0] op);
    return op inside {ALU_DIV, ALU_MOD};
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl_if
// Request/response bus between the two ALU clients and the controller.
//   req_valid/req_ready [1:0] : per-requester request handshake
//   req_op0/a0/b0, req_op1/a1/b1 : op code and operands of each requester
//   rsp_valid/rsp_ready [1:0] : per-requester response handshake
//   rsp_y, rsp_zero, rsp_dz   : shared captured result, qualified by rsp_valid
// master = requester side, slave = controller side.
// -----------------------------------------------------------------------------
interface alu_share_ctrl_if;

  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_op0;
  logic [3:0]  req_op1;
  logic [31:0] req_a0;
  logic [31:0] req_b0;
  logic [31:0] req_a1;
  logic [31:0] req_b1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_y;
  logic        rsp_zero;
  logic        rsp_dz;

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_zero, rsp_dz
  );

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_zero, rsp_dz
  );

endinterface

// File: rtl/alu_share_ctrl_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin arbiter.
//   req[1:0] in  : request lines
//   prio     in  : requester that wins when both request
//   gnt[1:0] out : one-hot grant (zero when nobody requests)
//   any      out : at least one request present
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt,
  output logic       any
);

  always_comb begin
    // NOTE: default assigned first so every path drives gnt and no latch is inferred.
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  assign any = |req;

endmodule

// File: rtl/alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl
// Time-shares one external combinational ALU between two requesters.
// A request is granted round-robin in IDLE, its operands are registered onto
// alu_* and held for the evaluation window (MULDIV_CYCLES for MUL/DIV/MOD,
// one cycle otherwise), then y/zero are captured and returned on the
// granted requester's response channel. One operation in flight at a time.
//   clk, rst_n           : clock, asynchronous active-low reset
//   bus (slave)          : request/response handshakes, operands, result
//   alu_a, alu_b, alu_op : registered ALU inputs (held outside EXEC too)
//   alu_y, alu_zero      : ALU result and zero flag
//   busy                 : operation in flight (state not IDLE)
// MULDIV_CYCLES legal range is 1..15.
// -----------------------------------------------------------------------------
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_share_ctrl_if.slave bus,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  output logic [3:0]      alu_op,
  input  logic [31:0]     alu_y,
  input  logic            alu_zero,
  output logic            busy
);

  // Counter load for the long window: EXEC lasts cnt+1 cycles.
  localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gnt_q, gnt_d;       // index of the requester owning the op
  logic [31:0]       alu_a_q, alu_a_d;
  logic [31:0]       alu_b_q, alu_b_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [31:0]       rsp_y_q, rsp_y_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_dz_q, rsp_dz_d;

  logic [1:0]        arb_gnt;
  logic              arb_any;
  logic [3:0]        sel_op;
  logic [31:0]       sel_a;
  logic [31:0]       sel_b;

  rr_arb2 u_arb (
    .req  (bus.req_valid),
    .prio (prio_q),
    .gnt  (arb_gnt),
    .any  (arb_any)
  );

  assign sel_op = arb_gnt[1] ? bus.req_op1 : bus.req_op0;
  assign sel_a  = arb_gnt[1] ? bus.req_a1  : bus.req_a0;
  assign sel_b  = arb_gnt[1] ? bus.req_b1  : bus.req_b0;

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    rsp_y_d    = rsp_y_q;
    rsp_zero_d = rsp_zero_q;
    rsp_dz_d   = rsp_dz_q;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          alu_op_d = sel_op;
          alu_a_d  = sel_a;
          alu_b_d  = sel_b;
          gnt_d    = arb_gnt[1];
          cnt_d    = is_multicycle(sel_op) ? MC_LOAD : '0;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rsp_y_d    = alu_y;
          rsp_zero_d = alu_zero;
          rsp_dz_d   = is_divide(alu_op_q) && (alu_b_q == '0);
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        // Only the owner's ready bit can release the result.
        if (bus.rsp_ready[gnt_q]) begin
          prio_d  = ~gnt_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      prio_q     <= 1'b0;
      cnt_q      <= '0;
      gnt_q      <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      rsp_y_q    <= '0;
      rsp_zero_q <= 1'b0;
      rsp_dz_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q    <= state_d;
      prio_q     <= prio_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      rsp_y_q    <= rsp_y_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_dz_q   <= rsp_dz_d;
    end
  end

  // req_ready follows req_valid combinationally in IDLE (winner only).
  assign bus.req_ready = (state_q == ST_IDLE) ? arb_gnt : 2'b00;
  assign bus.rsp_valid = (state_q == ST_RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_dz    = rsp_dz_q;

  assign alu_a  = alu_a_q;
  assign alu_b  = alu_b_q;
  assign alu_op = alu_op_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_share_ctrl
// Scoreboard bench for alu_share_ctrl. A stand-in ALU whose result is only
// correct once its inputs have been held for the op's window; a reference
// model of arbitration, latency and results; per-cycle monitor on negedge.
// -----------------------------------------------------------------------------
module tb_alu_share_ctrl;
  import alu_share_ctrl_pkg::*;

  localparam int MC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_share_ctrl_if bus();

  logic [31:0] alu_a, alu_b, alu_y;
  logic [3:0]  alu_op;
  logic        alu_zero, busy;

  alu_share_ctrl #(.MULDIV_CYCLES(MC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_y    (alu_y),
    .alu_zero (alu_zero),
    .busy     (busy)
  );

  // ---------------- requester drive ----------------
  logic        rv0 = 1'b0, rv1 = 1'b0;
  logic [3:0]  op_r [2];
  logic [31:0] a_r  [2];
  logic [31:0] b_r  [2];
  logic [1:0]  rsp_rdy = 2'b00;
  int          mode = 0;            // 0: always ready, 1: random, 2: hold off

  assign bus.req_valid = {rv1, rv0};
  assign bus.req_op0   = op_r[0];
  assign bus.req_a0    = a_r[0];
  assign bus.req_b0    = b_r[0];
  assign bus.req_op1   = op_r[1];
  assign bus.req_a1    = a_r[1];
  assign bus.req_b1    = b_r[1];
  assign bus.rsp_ready = rsp_rdy;

  initial begin
    for (int i = 0; i < 2; i++) begin
      op_r[i] = '0; a_r[i] = '0; b_r[i] = '0;
    end
  end

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $signed(a) >>> b[4:0];
      ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'b0, a < b};
      ALU_MUL:  r = a * b;
      ALU_DIV:  r = (b == 0) ? 32'd0 : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a
                  : 32'($signed(a) / $signed(b));
      ALU_MOD:  r = (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0
                  : 32'($signed(a) % $signed(b));
      default:  r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic int window(input logic [3:0] op);
    return (op == ALU_MUL || op == ALU_DIV || op == ALU_MOD) ? MC : 1;
  endfunction

  // Stand-in ALU: result is scrambled until inputs have been stable for the
  // op's window, emulating an unsettled multicycle path.
  logic [67:0] alu_prev = '0;
  int          stab = 0;
  always @(negedge clk) begin
    if ({alu_op, alu_a, alu_b} == alu_prev) stab <= (stab < 100) ? stab + 1 : stab;
    else stab <= 1;
    alu_prev <= {alu_op, alu_a, alu_b};
  end
  always_comb begin
    alu_y    = ref_alu(alu_op, alu_a, alu_b);
    if (stab < window(alu_op)) alu_y = alu_y ^ 32'hA5A5_5A5A;
    alu_zero = (alu_y == 32'd0);
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    int          port;
    logic [3:0]  op;
    logic [31:0] a, b, y;
    logic        zero, dz;
    int          c;
    int          lat;
  } exp_t;

  typedef struct {
    int          port;
    logic [31:0] y;
  } rsp_t;

  exp_t sb[$];
  rsp_t rsp_log[$];
  int   act_gnt[$];
  logic prio_m = 1'b0;
  logic [31:0] last_y;
  logic last_zero, last_dz;
  int   last_port;

  function automatic logic [1:0] winner(input logic [1:0] v, input logic pr);
    if (v == 2'b11) return pr ? 2'b10 : 2'b01;
    return v;
  endfunction

  logic       m_busy;
  logic [1:0] m_ready, m_rv;
  exp_t       m_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      prio_m = 1'b0;
    end else begin
      m_busy = (sb.size() != 0);
      if (!m_busy) begin
        m_ready = winner(bus.req_valid, prio_m);
        m_rv    = 2'b00;
      end else begin
        m_ready = 2'b00;
        m_rv    = (cyc - sb[0].c >= sb[0].lat + 1) ? (sb[0].port == 1 ? 2'b10 : 2'b01) : 2'b00;
      end
      check("req_ready", {30'b0, bus.req_ready}, {30'b0, m_ready});
      check("busy", {31'b0, busy}, {31'b0, m_busy});
      check("rsp_valid", {30'b0, bus.rsp_valid}, {30'b0, m_rv});
      for (int p = 0; p < 2; p++)
        if (bus.req_valid[p] && bus.req_ready[p]) act_gnt.push_back(p);
      if (m_busy) begin
        check("alu_op_hold", {28'b0, alu_op}, {28'b0, sb[0].op});
        check("alu_a_hold", alu_a, sb[0].a);
        check("alu_b_hold", alu_b, sb[0].b);
      end
      if (m_rv != 2'b00) begin
        check("rsp_y", bus.rsp_y, sb[0].y);
        check("rsp_zero", {31'b0, bus.rsp_zero}, {31'b0, sb[0].zero});
        check("rsp_dz", {31'b0, bus.rsp_dz}, {31'b0, sb[0].dz});
        if ((m_rv & rsp_rdy) != 2'b00) begin
          last_y    = bus.rsp_y;
          last_zero = bus.rsp_zero;
          last_dz   = bus.rsp_dz;
          last_port = sb[0].port;
          rsp_log.push_back('{port: sb[0].port, y: bus.rsp_y});
          prio_m = (sb[0].port == 0);
          void'(sb.pop_front());
        end
      end else if (!m_busy && m_ready != 2'b00) begin
        m_e.port = m_ready[1] ? 1 : 0;
        m_e.op   = m_ready[1] ? bus.req_op1 : bus.req_op0;
        m_e.a    = m_ready[1] ? bus.req_a1  : bus.req_a0;
        m_e.b    = m_ready[1] ? bus.req_b1  : bus.req_b0;
        m_e.y    = ref_alu(m_e.op, m_e.a, m_e.b);
        m_e.zero = (m_e.y == 32'd0);
        m_e.dz   = (m_e.op == ALU_DIV || m_e.op == ALU_MOD) && (m_e.b == 32'd0);
        m_e.c    = cyc;
        m_e.lat  = window(m_e.op);
        sb.push_back(m_e);
      end
    end
  end

  // ---------------- response-ready driver ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      case (mode)
        0:       rsp_rdy = 2'b11;
        1:       rsp_rdy = 2'($urandom);
        default: rsp_rdy = 2'b00;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at posedge+#1; returns at posedge+#1 after the accept edge.
  task automatic issue(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit got = 1'b0;
    op_r[p] = op; a_r[p] = a; b_r[p] = b;
    if (p == 0) rv0 = 1'b1; else rv1 = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.req_ready[p]) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    if (p == 0) rv0 = 1'b0; else rv1 = 1'b0;
    check($sformatf("accept_p%0d", p), {31'b0, got}, 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (sb.size() == 0) break;
    end
    #1;
    check("drain", sb.size(), 0);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'($urandom_range(0, 20));
      2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 19));
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_driver(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      issue(p, 4'($urandom_range(0, 15)), rnd_opnd(), rnd_opnd());
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_rsp_valid", {30'b0, bus.rsp_valid}, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_op", {28'b0, alu_op}, 0);
    check("rst_rsp_y", bus.rsp_y, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_req_ready", {30'b0, bus.req_ready}, 0);

    // Directed single ops
    issue(0, ALU_ADD, 32'd5, 32'd7);
    wait_idle();
    check("add_y", last_y, 32'd12);
    check("add_zero", {31'b0, last_zero}, 0);
    check("add_dz", {31'b0, last_dz}, 0);
    check("add_port", last_port, 0);

    issue(1, ALU_DIV, 32'hFFFF_FFEC, 32'd3);
    wait_idle();
    check("div_y", last_y, 32'hFFFF_FFFA);
    check("div_port", last_port, 1);

    issue(0, ALU_MOD, 32'd9, 32'd0);
    wait_idle();
    check("mod0_dz", {31'b0, last_dz}, 1);
    check("mod0_zero", {31'b0, last_zero}, 0);

    issue(1, ALU_DIV, 32'd9, 32'd0);
    wait_idle();
    check("div0_dz", {31'b0, last_dz}, 1);
    check("div0_zero", {31'b0, last_zero}, 1);

    // Contention: both continuously valid, grants must alternate from 0
    act_gnt.delete();
    rsp_log.delete();
    fork
      begin issue(0, ALU_SUB, 32'd10, 32'd3);   issue(0, ALU_SUB, 32'd10, 32'd3); end
      begin issue(1, ALU_XOR, 32'hF0, 32'h0F);  issue(1, ALU_XOR, 32'hF0, 32'h0F); end
    join
    wait_idle();
    check("cont_ngnt", act_gnt.size(), 4);
    for (int i = 0; i < act_gnt.size(); i++)
      check($sformatf("cont_gnt%0d", i), act_gnt[i], i % 2);
    for (int i = 0; i < rsp_log.size(); i++)
      check($sformatf("cont_y%0d", i), rsp_log[i].y, (rsp_log[i].port == 0) ? 32'd7 : 32'hFF);

    // Backpressure: response held for 10 cycles while port 0 waits
    mode = 2;
    @(posedge clk); #1;
    issue(1, ALU_ADD, $urandom, $urandom);
    fork
      issue(0, ALU_OR, 32'h1234, 32'h4321);
      begin
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("bp_req_ready", {30'b0, bus.req_ready}, 0);
        check("bp_busy", {31'b0, busy}, 1);
        check("bp_rsp_valid", {30'b0, bus.rsp_valid}, 32'd2);
        mode = 0;
      end
    join
    wait_idle();

    // Reset during EXEC of a MUL; prio was 1 before reset
    issue(0, ALU_MUL, 32'd1234, 32'd5678);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mrst_busy", {31'b0, busy}, 0);
    check("mrst_rsp_valid", {30'b0, bus.rsp_valid}, 0);
    check("mrst_req_ready", {30'b0, bus.req_ready}, 0);
    check("mrst_alu_a", alu_a, 0);
    check("mrst_alu_b", alu_b, 0);
    check("mrst_alu_op", {28'b0, alu_op}, 0);
    check("mrst_rsp_y", bus.rsp_y, 0);
    check("mrst_flags", {30'b0, bus.rsp_zero, bus.rsp_dz}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    act_gnt.delete();
    fork
      issue(0, ALU_AND, $urandom, $urandom);
      issue(1, ALU_AND, $urandom, $urandom);
    join
    wait_idle();
    check("post_rst_gnt", (act_gnt.size() > 0) ? act_gnt[0] : 99, 0);

    // Randomized traffic with random response backpressure
    mode = 1;
    fork
      rand_driver(0, 60);
      rand_driver(1, 60);
    join
    mode = 0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Two-requester controller that time-shares one combinational `alu` instance between two independent clients, e.g. the core issue port and a coprocessor/debug port. It arbitrates round-robin and registers the granted operands so they drive the ALU stable for a programmable number of cycles. MUL/DIV/MOD get a longer multicycle window; all other ops get one cycle. It captures `y`/`zero` and returns them on a per-requester valid/ready response channel. Only one operation is in flight at a time.

## Interface
- `MULDIV_CYCLES`, 4: ALU evaluation window for `ALU_MUL`/`ALU_DIV`/`ALU_MOD`; legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid[1:0]` in 2: request valid, one bit per requester.
- `req_ready[1:0]` out 2: request accepted on a `valid & ready` edge.
- `req_op0`, `req_op1` in 4 each: ALU op code, using the `ALU_*` encodings.
- `req_a0`, `req_b0`, `req_a1`, `req_b1` in 32 each: operands.
- `rsp_valid[1:0]` out 2: response valid for the requester owning it.
- `rsp_ready[1:0]` in 2: response consumed.
- `rsp_y` out 32: captured result, shared by both channels; qualified by `rsp_valid`.
- `rsp_zero` out 1: captured ALU `zero` flag.
- `rsp_dz` out 1: high when the op was DIV or MOD and the captured `b` was 0.
- `alu_a`, `alu_b` out 32 each: registered operands driven to the ALU.
- `alu_op` out 4: registered op code driven to the ALU.
- `alu_y` in 32: ALU result.
- `alu_zero` in 1: ALU zero flag.
- `busy` out 1: high when the state is not IDLE.

## Operation
- FSM has three states.
  - IDLE: no operation in flight.
  - EXEC: ALU inputs held; `cnt` counts down.
  - RESP: result held for the granted requester.
- IDLE arbitration:
  - When exactly one `req_valid` is set, that requester wins.
  - When both are set, requester `prio` wins.
  - `req_ready[g]=1` only in IDLE and only for the winner `g`. The other bit and all non-IDLE states give 0.
  - `req_ready` may depend combinationally on `req_valid`. Requesters must not make `valid` depend on `ready`.
- On accept:
  - Latch `op`, `a`, `b` into `alu_op`, `alu_a`, `alu_b`.
  - Record the grant `g`.
  - Load `cnt` with `L-1`, where L = `MULDIV_CYCLES` for MUL/DIV/MOD and 1 otherwise.
  - Go to EXEC.
- EXEC:
  - `alu_*` held constant.
  - While `cnt != 0`, decrement `cnt`.
  - When `cnt == 0`, capture `alu_y` into `rsp_y` and `alu_zero` into `rsp_zero`, compute `rsp_dz`, and go to RESP.
- RESP:
  - `rsp_valid[g]=1`; the other bit is 0.
  - On `rsp_ready[g]`: go to IDLE and set `prio = ~g`.
  - `rsp_ready` on the non-granted bit is ignored.
- Unknown op codes are forwarded unchanged with L=1; the result is whatever the ALU returns (0).
- `alu_*` hold their last values in IDLE and RESP; they are not zeroed.
- Reset values:
  - State IDLE; `prio`=0; `cnt`=0.
  - `alu_a`, `alu_b`, `alu_op`, `rsp_y` = 0.
  - `rsp_zero`, `rsp_dz`, `rsp_valid`, `req_ready`, `busy` = 0.
- Reset mid-operation: the in-flight op is discarded and no response is produced. The first request after reset release is handled as from IDLE with `prio`=0.

## Timing
- Accept edge T:
  - EXEC occupies cycles T+1 .. T+L.
  - Capture happens at edge T+L.
  - `rsp_valid` is high from cycle T+L+1 until the consuming edge R.
- After edge R, cycle R+1 is IDLE, and a new request can be accepted at edge R+1.
- Best-case occupancy is L+2 cycles per op: 3 for simple ops, 6 for MUL/DIV at the default.
- `alu_*` are stable for at least L full cycles before capture. The ALU MUL/DIV path is constrained as an L-cycle multicycle path from `alu_*` to the `rsp_y` register.
- Starvation bound: with both requesters continuously valid, grants strictly alternate.
- A new `req_valid` arriving during EXEC or RESP waits; requests are not queued.

## Structure
- `decode.vh` supplies `ALU_*` op codes.
- A shared header adds:
  - localparams for the FSM state encoding (IDLE=0, EXEC=1, RESP=2);
  - an `is_multicycle(op)` function returning true for MUL/DIV/MOD.
- Sub-module `rr_arb2`: a combinational 2-way round-robin arbiter.
  - Inputs: `req[1:0]`, `prio`.
  - Outputs: one-hot `gnt[1:0]`, `any`.
- `alu` is instantiated at the parent level, not inside this block.

## Test plan
- Simple op, requester 0: ADD with a=5, b=7 accepted at T. Required: `alu_op`=ADD from T+1, `rsp_valid[0]` at T+2, `rsp_y`=12, `rsp_zero`=0, `rsp_dz`=0.
- Multicycle op, requester 1: DIV with a=-20, b=3, `MULDIV_CYCLES`=4. Required: `rsp_valid[1]` at T+5, `rsp_y`=-6 (0xFFFFFFFA); `alu_a`/`alu_b` unchanged across T+1..T+4.
- Divide by zero: MOD with a=9, b=0 gives `rsp_dz`=1 and `rsp_zero`=0. DIV with a=9, b=0 gives `rsp_dz`=1 and `rsp_zero`=1.
- Contention: both requesters valid continuously with SUB 10-3 on port 0 and XOR 0xF0^0x0F on port 1. Required grant order is 0, 1, 0, 1, with results 7 and 0xFF matching the port.
- Backpressure: hold `rsp_ready`=0 for 10 cycles. Required: `rsp_valid`/`rsp_y` stable, `req_ready`=00, `busy`=1; accept proceeds the cycle after `rsp_ready`.
- Reset during EXEC of MUL: assert `rst_n`=0 at T+2. Required: all outputs 0 immediately, no `rsp_valid` after release, next grant goes to requester 0 when both are valid.
